eeg_fram_port_ctrl: RTL and testbench

//  Engine-side initiator for one FRAM lane. On a config command it runs a burst.
//  - WR: forwards an upstream source stream as address/data writes (ETOF_DAT_*).
//  - RD: issues a read-address stream (ETOF_ADD_*) and returns FTOE_DAT_* read data to a sink.

---
 rtl/eeg_fram_port_ctrl.sv | 177 +++++++++++++++++
 tb/tb_eeg_fram_port_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eeg_fram_port_ctrl.sv
// Engine-side initiator for one FRAM lane: a config command runs either a write
// burst (source stream forwarded as address/data beats) or a read burst (address stream out, data returned).
module eeg_fram_port_ctrl #(
   parameter int ADD_AW  = 12,
   parameter int DAT_DW  = 4,
   parameter int LEN_DW  = 12,
   parameter int MAX_OUT = 4,
   parameter int OUT_CW  = $clog2(MAX_OUT + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              CFG_VLD,
   output logic              CFG_RDY,
   input  logic [1:0]        CFG_CMD,
   input  logic [ADD_AW-1:0] CFG_BASE,
   input  logic [LEN_DW-1:0] CFG_LEN,
   input  logic              SRC_VLD,
   output logic              SRC_RDY,
   input  logic [DAT_DW-1:0] SRC_DAT,
   output logic              ETOF_DAT_VLD,
   output logic              ETOF_DAT_LST,
   input  logic              ETOF_DAT_RDY,
   output logic [ADD_AW-1:0] ETOF_DAT_ADD,
   output logic [DAT_DW-1:0] ETOF_DAT_DAT,
   output logic              ETOF_ADD_VLD,
   output logic              ETOF_ADD_LST,
   input  logic              ETOF_ADD_RDY,
   output logic [ADD_AW-1:0] ETOF_ADD_ADD,
   input  logic              FTOE_DAT_VLD,
   input  logic              FTOE_DAT_LST,
   output logic              FTOE_DAT_RDY,
   input  logic [DAT_DW-1:0] FTOE_DAT_DAT,
   output logic              SNK_VLD,
   output logic              SNK_LST,
   input  logic              SNK_RDY,
   output logic [DAT_DW-1:0] SNK_DAT,
   output logic              STS_DONE,
   output logic              STS_ERR
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WR   = 2'd1,
      S_RD   = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADD_AW-1:0]   r_base;
   logic [LEN_DW-1:0]   r_len;
   logic [LEN_DW-1:0]   r_beat;
   logic [LEN_DW-1:0]   r_issue;
   logic [LEN_DW-1:0]   r_ret;
   logic [OUT_CW-1:0]   r_out_cnt;
   logic                r_issue_done;
   logic                r_done;
   logic                r_err;

   logic w_cmd_wr;
   logic w_cmd_rd;
   logic w_cfg_fire;
   logic w_wr_fire;
   logic w_add_fire;
   logic w_ret_fire;
   logic w_wr_last;
   logic w_iss_last;
   logic w_ret_last;
   logic w_out_ok;

   assign w_cmd_wr   = (CFG_CMD == 2'b01);
   assign w_cmd_rd   = (CFG_CMD == 2'b10);
   assign w_cfg_fire = CFG_VLD & CFG_RDY;
   assign w_wr_fire  = ETOF_DAT_VLD & ETOF_DAT_RDY;
   assign w_add_fire = ETOF_ADD_VLD & ETOF_ADD_RDY;
   assign w_ret_fire = FTOE_DAT_VLD & FTOE_DAT_RDY;
   assign w_wr_last  = (r_beat == r_len);
   assign w_iss_last = (r_issue == r_len);
   assign w_ret_last = (r_ret == r_len);
   assign w_out_ok   = (r_out_cnt < OUT_CW'(MAX_OUT));

   // Address offsets are truncated to ADD_AW so bursts wrap past the top of FRAM
   assign ETOF_DAT_ADD = r_base + ADD_AW'(r_beat);
   assign ETOF_ADD_ADD = r_base + ADD_AW'(r_issue);
   assign ETOF_DAT_DAT = SRC_DAT;
   assign SNK_DAT      = FTOE_DAT_DAT;
   assign STS_DONE     = r_done;
   assign STS_ERR      = r_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      CFG_RDY      = 1'b0;
      SRC_RDY      = 1'b0;
      ETOF_DAT_VLD = 1'b0;
      ETOF_DAT_LST = 1'b0;
      ETOF_ADD_VLD = 1'b0;
      ETOF_ADD_LST = 1'b0;
      FTOE_DAT_RDY = 1'b0;
      SNK_VLD      = 1'b0;
      SNK_LST      = 1'b0;
      case (r_state)
         S_IDLE: begin
            CFG_RDY = 1'b1;
            if (CFG_VLD) begin
               if (w_cmd_wr)      w_state_nxt = S_WR;
               else if (w_cmd_rd) w_state_nxt = S_RD;
            end
         end
         S_WR: begin
            ETOF_DAT_VLD = SRC_VLD;
            SRC_RDY      = ETOF_DAT_RDY;
            ETOF_DAT_LST = w_wr_last;
            if (SRC_VLD && ETOF_DAT_RDY && w_wr_last) w_state_nxt = S_IDLE;
         end
         S_RD: begin
            ETOF_ADD_VLD = ~r_issue_done & w_out_ok;
            ETOF_ADD_LST = w_iss_last;
            FTOE_DAT_RDY = SNK_RDY;
            SNK_VLD      = FTOE_DAT_VLD;
            SNK_LST      = w_ret_last;
            if (FTOE_DAT_VLD && SNK_RDY && w_ret_last) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_base       <= '0;
         r_len        <= '0;
         r_beat       <= '0;
         r_issue      <= '0;
         r_ret        <= '0;
         r_out_cnt    <= '0;
         r_issue_done <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         if (w_cfg_fire) begin
            r_base       <= CFG_BASE;
            r_len        <= CFG_LEN;
            r_beat       <= '0;
            r_issue      <= '0;
            r_ret        <= '0;
            r_out_cnt    <= '0;
            r_issue_done <= 1'b0;
            r_err        <= ~(w_cmd_wr | w_cmd_rd);
         end
         if (w_wr_fire) begin
            r_beat <= r_beat + LEN_DW'(1);
            if (w_wr_last) r_done <= 1'b1;
         end
         if (w_add_fire) begin
            r_issue <= r_issue + LEN_DW'(1);
            if (w_iss_last) r_issue_done <= 1'b1;
         end
         // A wrong FTOE_DAT_LST is flagged but the internal count stays authoritative
         if (w_ret_fire) begin
            r_ret <= r_ret + LEN_DW'(1);
            if (w_ret_last) r_done <= 1'b1;
            if (FTOE_DAT_LST != w_ret_last) r_err <= 1'b1;
         end
         case ({w_add_fire, w_ret_fire && (r_out_cnt != '0)})
            2'b10:   r_out_cnt <= r_out_cnt + OUT_CW'(1);
            2'b01:   r_out_cnt <= r_out_cnt - OUT_CW'(1);
            default: r_out_cnt <= r_out_cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_eeg_fram_port_ctrl.sv
// Scoreboard bench for eeg_fram_port_ctrl: expected beats are queued when a burst is
// commanded; a negedge monitor pops them on every DUT handshake and checks per-cycle gating.
module tb_eeg_fram_port_ctrl;
   localparam int AW = 12;
   localparam int DW = 4;
   localparam int LW = 12;
   localparam int MO = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          CFG_VLD = 1'b0;
   logic          CFG_RDY;
   logic [1:0]    CFG_CMD = 2'b00;
   logic [AW-1:0] CFG_BASE = '0;
   logic [LW-1:0] CFG_LEN = '0;
   logic          SRC_VLD;
   logic          SRC_RDY;
   logic [DW-1:0] SRC_DAT;
   logic          ETOF_DAT_VLD, ETOF_DAT_LST, ETOF_DAT_RDY;
   logic [AW-1:0] ETOF_DAT_ADD;
   logic [DW-1:0] ETOF_DAT_DAT;
   logic          ETOF_ADD_VLD, ETOF_ADD_LST, ETOF_ADD_RDY;
   logic [AW-1:0] ETOF_ADD_ADD;
   logic          FTOE_DAT_VLD, FTOE_DAT_LST, FTOE_DAT_RDY;
   logic [DW-1:0] FTOE_DAT_DAT;
   logic          SNK_VLD, SNK_LST, SNK_RDY;
   logic [DW-1:0] SNK_DAT;
   logic          STS_DONE, STS_ERR;

   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   eeg_fram_port_ctrl #(.ADD_AW(AW), .DAT_DW(DW), .LEN_DW(LW), .MAX_OUT(MO)) dut (
      .clk(clk), .rst_n(rst_n),
      .CFG_VLD(CFG_VLD), .CFG_RDY(CFG_RDY), .CFG_CMD(CFG_CMD), .CFG_BASE(CFG_BASE), .CFG_LEN(CFG_LEN),
      .SRC_VLD(SRC_VLD), .SRC_RDY(SRC_RDY), .SRC_DAT(SRC_DAT),
      .ETOF_DAT_VLD(ETOF_DAT_VLD), .ETOF_DAT_LST(ETOF_DAT_LST), .ETOF_DAT_RDY(ETOF_DAT_RDY),
      .ETOF_DAT_ADD(ETOF_DAT_ADD), .ETOF_DAT_DAT(ETOF_DAT_DAT),
      .ETOF_ADD_VLD(ETOF_ADD_VLD), .ETOF_ADD_LST(ETOF_ADD_LST), .ETOF_ADD_RDY(ETOF_ADD_RDY),
      .ETOF_ADD_ADD(ETOF_ADD_ADD),
      .FTOE_DAT_VLD(FTOE_DAT_VLD), .FTOE_DAT_LST(FTOE_DAT_LST), .FTOE_DAT_RDY(FTOE_DAT_RDY),
      .FTOE_DAT_DAT(FTOE_DAT_DAT),
      .SNK_VLD(SNK_VLD), .SNK_LST(SNK_LST), .SNK_RDY(SNK_RDY), .SNK_DAT(SNK_DAT),
      .STS_DONE(STS_DONE), .STS_ERR(STS_ERR)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [AW-1:0] add;
      logic [DW-1:0] dat;
      logic          lst;
   } beat_t;
   typedef struct {
      int            due;
      logic [AW-1:0] add;
   } pend_t;
   typedef enum {P_IDLE, P_WR, P_RD} phase_t;

   beat_t         q_wr[$];
   beat_t         q_radd[$];
   beat_t         q_snk[$];
   logic [DW-1:0] q_src[$];
   pend_t         pend[$];
   logic [DW-1:0] mem [0:4095];

   phase_t phase = P_IDLE;
   int     issued = 0, outst = 0, peak = 0;
   logic   done_pend = 1'b0, err_pend = 1'b0;
   int     cur_len = 0, inj_idx = -1;
   int     wrdy_mode = 0, adrdy_mode = 0, snk_mode = 0, snk_block_until = 0;

   // ready generators for the three slave-side handshakes
   initial begin
      ETOF_DAT_RDY = 1'b0; ETOF_ADD_RDY = 1'b0; SNK_RDY = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (wrdy_mode)
            0:       ETOF_DAT_RDY = 1'b1;
            1:       ETOF_DAT_RDY = ~ETOF_DAT_RDY;
            default: ETOF_DAT_RDY = 1'($urandom_range(1));
         endcase
         ETOF_ADD_RDY = (adrdy_mode == 0) ? 1'b1 : 1'($urandom_range(1));
         SNK_RDY = (cyc < snk_block_until) ? 1'b0 : ((snk_mode == 0) ? 1'b1 : 1'($urandom_range(1)));
      end
   end

   // upstream source: VLD held until accepted, random gaps otherwise
   initial begin
      bit f;
      SRC_VLD = 1'b0; SRC_DAT = '0;
      forever begin
         @(negedge clk);
         f = SRC_VLD && SRC_RDY;
         @(posedge clk); #1;
         if (!rst_n) begin
            q_src.delete();
            SRC_VLD = 1'b0;
         end else begin
            if (f) void'(q_src.pop_front());
            if (!SRC_VLD || f) SRC_VLD = (q_src.size() > 0) && ($urandom_range(3) != 0);
            if (SRC_VLD) SRC_DAT = q_src[0];
         end
      end
   end

   // FRAM read model: returns mem[addr] three cycles after the address is accepted
   initial begin
      bit af, df;
      logic [AW-1:0] aa;
      int ridx;
      ridx = 0;
      FTOE_DAT_VLD = 1'b0; FTOE_DAT_LST = 1'b0; FTOE_DAT_DAT = '0;
      forever begin
         @(negedge clk);
         af = ETOF_ADD_VLD && ETOF_ADD_RDY;
         aa = ETOF_ADD_ADD;
         df = FTOE_DAT_VLD && FTOE_DAT_RDY;
         @(posedge clk); #1;
         if (!rst_n) begin
            pend.delete();
            ridx = 0;
            FTOE_DAT_VLD = 1'b0; FTOE_DAT_LST = 1'b0;
         end else begin
            if (af) pend.push_back('{cyc + 3, aa});
            if (df) begin
               void'(pend.pop_front());
               ridx = (ridx == cur_len) ? 0 : ridx + 1;
            end
            if (pend.size() > 0 && pend[0].due <= cyc) begin
               FTOE_DAT_VLD = 1'b1;
               FTOE_DAT_DAT = mem[pend[0].add];
               FTOE_DAT_LST = (ridx == cur_len) ^ (ridx == inj_idx);
            end else begin
               FTOE_DAT_VLD = 1'b0; FTOE_DAT_LST = 1'b0;
            end
         end
      end
   end

   logic          wr_stall = 1'b0, add_stall = 1'b0;
   logic [31:0]   prev_w = '0, prev_a = '0;

   always @(negedge clk) begin
      beat_t e;
      if (!rst_n) begin
         chk("rst_cfg_rdy", 32'(CFG_RDY), 32'd1);
         chk("rst_outs", {24'd0, ETOF_DAT_VLD, ETOF_ADD_VLD, SNK_VLD, ETOF_DAT_LST,
                          ETOF_ADD_LST, SNK_LST, STS_DONE, STS_ERR}, 32'd0);
         phase = P_IDLE; done_pend = 1'b0; err_pend = 1'b0;
         issued = 0; outst = 0; wr_stall = 1'b0; add_stall = 1'b0;
         q_wr.delete(); q_radd.delete(); q_snk.delete();
      end else begin
         chk("cfg_rdy", 32'(CFG_RDY), 32'(phase == P_IDLE));
         chk("sts_done", 32'(STS_DONE), 32'(done_pend));
         chk("sts_err", 32'(STS_ERR), 32'(err_pend));
         done_pend = 1'b0; err_pend = 1'b0;
         chk("src_rdy", 32'(SRC_RDY), 32'(phase == P_WR && ETOF_DAT_RDY));
         chk("wr_vld", 32'(ETOF_DAT_VLD), 32'(phase == P_WR && SRC_VLD));
         chk("add_vld", 32'(ETOF_ADD_VLD), 32'(phase == P_RD && issued <= cur_len && outst < MO));
         chk("ftoe_rdy", 32'(FTOE_DAT_RDY), 32'(phase == P_RD && SNK_RDY));
         chk("snk_vld", 32'(SNK_VLD), 32'(phase == P_RD && FTOE_DAT_VLD));
         if (wr_stall) chk("wr_hold", {15'd0, ETOF_DAT_VLD, ETOF_DAT_ADD, ETOF_DAT_DAT}, prev_w);
         if (add_stall) chk("add_hold", {18'd0, ETOF_ADD_VLD, ETOF_ADD_ADD, ETOF_ADD_LST}, prev_a);
         wr_stall  = ETOF_DAT_VLD && !ETOF_DAT_RDY;
         prev_w    = {15'd0, ETOF_DAT_VLD, ETOF_DAT_ADD, ETOF_DAT_DAT};
         add_stall = ETOF_ADD_VLD && !ETOF_ADD_RDY;
         prev_a    = {18'd0, ETOF_ADD_VLD, ETOF_ADD_ADD, ETOF_ADD_LST};

         if (ETOF_DAT_VLD && ETOF_DAT_RDY) begin
            checks++;
            if (q_wr.size() == 0) begin
               failures++;
               $display("FAIL wr_beat unexpected add=%0h t=%0t", ETOF_DAT_ADD, $time);
            end else begin
               e = q_wr.pop_front();
               chk("wr_add", 32'(ETOF_DAT_ADD), 32'(e.add));
               chk("wr_dat", 32'(ETOF_DAT_DAT), 32'(e.dat));
               chk("wr_lst", 32'(ETOF_DAT_LST), 32'(e.lst));
               if (e.lst) begin phase = P_IDLE; done_pend = 1'b1; end
            end
         end
         if (ETOF_ADD_VLD && ETOF_ADD_RDY) begin
            checks++;
            if (q_radd.size() == 0) begin
               failures++;
               $display("FAIL rd_addr unexpected add=%0h t=%0t", ETOF_ADD_ADD, $time);
            end else begin
               e = q_radd.pop_front();
               chk("rd_add", 32'(ETOF_ADD_ADD), 32'(e.add));
               chk("rd_add_lst", 32'(ETOF_ADD_LST), 32'(e.lst));
            end
            issued++; outst++;
            if (outst > peak) peak = outst;
         end
         if (SNK_VLD && SNK_RDY) begin
            checks++;
            if (q_snk.size() == 0) begin
               failures++;
               $display("FAIL snk_beat unexpected dat=%0h t=%0t", SNK_DAT, $time);
            end else begin
               e = q_snk.pop_front();
               chk("snk_dat", 32'(SNK_DAT), 32'(e.dat));
               chk("snk_lst", 32'(SNK_LST), 32'(e.lst));
               if (FTOE_DAT_LST != e.lst) err_pend = 1'b1;
               if (e.lst) begin phase = P_IDLE; done_pend = 1'b1; end
            end
            outst--;
         end
         if (CFG_VLD && CFG_RDY) begin
            issued = 0; outst = 0;
            if (CFG_CMD == 2'b01)      phase = P_WR;
            else if (CFG_CMD == 2'b10) phase = P_RD;
            else                       err_pend = 1'b1;
         end
      end
   end

   task automatic issue_cfg(input logic [1:0] cmd, input logic [AW-1:0] base, input logic [LW-1:0] len);
      bit ok;
      ok = 1'b0;
      @(posedge clk); #1;
      CFG_VLD = 1'b1; CFG_CMD = cmd; CFG_BASE = base; CFG_LEN = len;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = CFG_RDY;
      end
      if (!ok) begin
         failures++;
         $display("FAIL cfg_accept timeout cmd=%0d", cmd);
      end
      @(posedge clk); #1;
      CFG_VLD = 1'b0; CFG_CMD = 2'($urandom_range(3));
   endtask

   task automatic wait_idle(input string nm);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(negedge clk);
         ok = (phase == P_IDLE) && (q_wr.size() + q_radd.size() + q_snk.size() == 0);
      end
      if (!ok) begin
         failures++;
         $display("FAIL %s burst timeout left=%0d", nm, q_wr.size() + q_radd.size() + q_snk.size());
      end
      repeat (2) @(negedge clk);
      chk({nm, "_idle_rdy"}, 32'(CFG_RDY), 32'd1);
   endtask

   function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] base, input int i);
      return AW'((int'(base) + i) % 4096);
   endfunction

   task automatic run_wr(input logic [AW-1:0] base, input int len, input int wmode);
      logic [DW-1:0] d;
      wrdy_mode = wmode; cur_len = len;
      for (int i = 0; i <= len; i++) begin
         d = DW'($urandom);
         q_src.push_back(d);
         q_wr.push_back('{wrap_add(base, i), d, i == len});
      end
      issue_cfg(2'b01, base, LW'(len));
      wait_idle("wr");
   endtask

   task automatic push_rd(input logic [AW-1:0] base, input int len);
      cur_len = len;
      for (int i = 0; i <= len; i++) begin
         q_radd.push_back('{wrap_add(base, i), '0, i == len});
         q_snk.push_back('{'0, mem[wrap_add(base, i)], i == len});
      end
   endtask

   task automatic run_rd(input logic [AW-1:0] base, input int len, input int amode, input int smode, input int inj);
      adrdy_mode = amode; snk_mode = smode; inj_idx = inj;
      push_rd(base, len);
      issue_cfg(2'b10, base, LW'(len));
      wait_idle("rd");
      inj_idx = -1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = DW'($urandom);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run_wr(12'h010, 3, 0);
      run_wr(12'hFFE, 3, 0);
      run_wr(AW'($urandom), 9, 1);
      run_wr(AW'($urandom), 0, 2);

      run_rd(12'h100, 7, 0, 0, -1);
      peak = 0;
      snk_block_until = cyc + 14;
      run_rd(12'h200, 11, 0, 0, -1);
      chk("out_peak", 32'(peak), 32'(MO));
      run_rd(12'hFFD, 5, 1, 1, -1);
      run_rd(AW'($urandom), 0, 1, 1, -1);
      run_rd(12'h300, 6, 0, 1, 2);

      issue_cfg(2'b11, 12'h123, 12'd4);
      repeat (4) @(negedge clk);
      issue_cfg(2'b00, 12'h456, 12'd0);
      repeat (4) @(negedge clk);

      for (int n = 0; n < 12; n++) begin
         if ($urandom_range(1) == 1) run_wr(AW'($urandom), int'($urandom_range(15)), int'($urandom_range(2)));
         else run_rd(AW'($urandom), int'($urandom_range(15)), int'($urandom_range(1)), int'($urandom_range(1)), -1);
      end

      adrdy_mode = 0; snk_mode = 1;
      push_rd(12'h500, 30);
      issue_cfg(2'b10, 12'h500, 12'd30);
      repeat (12) @(posedge clk);
      #3 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("post_rst_rdy", 32'(CFG_RDY), 32'd1);
      run_rd(12'h040, 3, 0, 0, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
